// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with blanking gaps and a frame-aligned shadow register.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DWELL_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   active_q, active_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_full_q, pend_full_d;
    logic          in_ready_q, in_ready_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    digit_q, digit_d;
    logic          frame_done_q, frame_done_d;

    logic          boundary;
    logic          accept;
    logic          lit;

    // Handshake: a word transfers on any rising edge where in_valid and in_ready are both high.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        boundary    = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d  = ST_BLANK;
                    cnt_d    = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // An accept can only happen while the shadow is empty, so the two arms never collide.
        if (boundary && pend_full_q) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end else if (accept) begin
            pending_d   = in_data;
            pend_full_d = 1'b1;
        end

`ifdef SEG_SCAN_LZB_EN
        case (idx_d)
            2'd0:    lit = 1'b1;
            2'd1:    lit = |active_d[15:4];
            2'd2:    lit = |active_d[15:8];
            default: lit = |active_d[15:12];
        endcase
`else
        lit = 1'b1;
`endif

        // Outputs are derived from next state so the registered copies line up with state_q.
        an_d         = 4'b1111;
        digit_d      = digit_q;
        if (state_d == ST_SHOW) begin
            digit_d = active_d[{idx_d, 2'b00} +: 4];
            if (lit) begin
                an_d = ~(4'b0001 << idx_d);
            end
        end
        frame_done_d = (state_d == ST_SHOW) && (idx_d == 2'd3) && (cnt_d == SHOW_LAST);
        in_ready_d   = ~pend_full_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            active_q     <= 16'h0000;
            pending_q    <= 16'h0000;
            pend_full_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            an_q         <= 4'b1111;
            digit_q      <= 4'h0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_full_q  <= pend_full_d;
            in_ready_q   <= in_ready_d;
            an_q         <= an_d;
            digit_q      <= digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign an         = an_q;
    assign digit      = digit_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a frame-arithmetic reference model checks every cycle,
// and directed scenarios add end-to-end checks on top.
module tb_seg_scan_ctrl;

    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        frame_done;

    seg_scan_ctrl #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .an         (an),
        .digit      (digit),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;

    // Reference model: time since release, displayed word, and words accepted but not yet shown.
    int          t;
    bit          rdy_ok;
    logic [15:0] active_m;
    logic [15:0] exp_q[$];
    logic [3:0]  digit_m;
    bit          last_acc;

    task automatic check_outputs();
        int p, slot, w;
        bit show, lit, e_fd, e_rdy;
        logic [3:0] one, e_an;
        p    = t % FRAME;
        slot = p / SLOT;
        w    = p % SLOT;
        show = (w >= BLANK);
        lit  = show;
`ifdef SEG_SCAN_LZB_EN
        if (show && slot > 0 && (active_m >> (4 * slot)) == 16'h0) lit = 1'b0;
`endif
        one  = 4'b0001 << slot;
        e_an = lit ? ~one : 4'b1111;
        if (show) digit_m = active_m[4*slot +: 4];
        e_fd  = (slot == 3) && (w == SLOT - 1);
        e_rdy = rdy_ok && (exp_q.size() == 0);
        checks += 4;
        if (an !== e_an) begin
            failures++;
            $display("FAIL an t=%0d got=%b exp=%b", t, an, e_an);
        end
        if (digit !== digit_m) begin
            failures++;
            $display("FAIL digit t=%0d got=%h exp=%h", t, digit, digit_m);
        end
        if (frame_done !== e_fd) begin
            failures++;
            $display("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, e_fd);
        end
        if (in_ready !== e_rdy) begin
            failures++;
            $display("FAIL in_ready t=%0d got=%b exp=%b", t, in_ready, e_rdy);
        end
    endtask

    // One clock: update the model on the rising edge, check DUT outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            t        = 0;
            rdy_ok   = 1'b0;
            active_m = 16'h0;
            digit_m  = 4'h0;
            last_acc = 1'b0;
            exp_q.delete();
        end else begin
            last_acc = in_valid && rdy_ok && (exp_q.size() == 0);
            if ((t % FRAME) == FRAME - 1 && exp_q.size() != 0) begin
                active_m = exp_q.pop_front();
            end else if (last_acc) begin
                exp_q.push_back(in_data);
            end
            t++;
            rdy_ok = 1'b1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [15:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            step();
            done = last_acc;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL offer_timeout got=not_accepted exp=accepted data=%h", d);
        end
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != ph; i++) step();
    endtask

    task automatic test_reset();
        int pulses;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0;
        run(3);
        reset_n = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (frame_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL reset_frame_pulses got=%0d exp=2", pulses);
        end
    endtask

    task automatic test_load();
        logic [3:0] seen[4];
        wait_phase(SLOT + 1);
        offer(16'h1A2F);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_ready_drop got=%b exp=0", in_ready);
        end
        wait_phase(0);
        for (int k = 0; k < 4; k++) seen[k] = 4'hx;
        for (int i = 0; i < FRAME; i++) begin
            step();
            for (int k = 0; k < 4; k++) if (an[k] === 1'b0) seen[k] = digit;
        end
        checks++;
        if ({seen[3], seen[2], seen[1], seen[0]} !== 16'h1A2F) begin
            failures++;
            $display("FAIL load_digits got=%h%h%h%h exp=1a2f", seen[3], seen[2], seen[1], seen[0]);
        end
    endtask

    task automatic test_backpressure();
        wait_phase(SLOT);
        offer(16'h1111);
        offer(16'h2222);
        run(2 * FRAME);
    endtask

    task automatic test_collision();
        wait_phase(FRAME - 1);
        in_valid = 1'b1;
        in_data  = 16'hC0DE;
        step();
        in_valid = 1'b0;
        run(3 * FRAME);
    endtask

    task automatic test_reset_mid();
        wait_phase(1);
        offer(16'h9876);
        wait_phase(2 * SLOT + BLANK + 1);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h1357;
        step();
        checks++;
        if (an !== 4'b1111 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=an%b/rdy%b exp=an1111/rdy0", an, in_ready);
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        run(2 * FRAME);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40 * FRAME; i++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom_range(0, 3) == 0);
                in_data  = 16'($urandom);
            end
            step();
        end
        in_valid = 1'b0;
        run(2 * FRAME);
    endtask

`ifdef SEG_SCAN_LZB_EN
    task automatic test_lzb();
        int high_low;
        offer(16'h0050);
        wait_phase(0);
        wait_phase(1);
        high_low = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (an[3] === 1'b0 || an[2] === 1'b0) high_low++;
        end
        checks++;
        if (high_low != 0) begin
            failures++;
            $display("FAIL lzb_high_anodes got=%0d exp=0", high_low);
        end
        offer(16'h0000);
        run(3 * FRAME);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        t        = 0;
        rdy_ok   = 1'b0;
        active_m = 16'h0;
        digit_m  = 4'h0;
        last_acc = 1'b0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0;
        test_reset();
        test_load();
        test_backpressure();
        test_collision();
        test_reset_mid();
`ifdef SEG_SCAN_LZB_EN
        test_lzb();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Display scheduler for the four-digit seven-segment display. It holds a 16-bit display word as four nibbles and time-multiplexes them onto the shared digit path, one anode at a time. Each digit is preceded by an all-off blanking gap to suppress ghosting. New words arrive through a valid/ready handshake into a shadow register and are applied only at frame boundaries, so a frame never mixes two words. It sits between the math block (producer) and the hex-to-segment decoder driving `seg`/`an`.

## Interface
- `DWELL_CYCLES`, 1024: clock cycles one digit's anode stays on; ≥1.
- `BLANK_CYCLES`, 16: cycles of all-anodes-off before each digit; ≥1.
- `clk` input 1: board clock; all logic on rising edge.
- `reset_n` input 1: reset, active low, synchronous; one clock, synchronous active-low reset.
- `in_data` input 16: display word; nibble k ([4k+3:4k]) goes to digit k, with digit 0 rightmost.
- `in_valid` input 1: producer has a word.
- `in_ready` output 1: shadow register empty; a word is accepted on `in_valid && in_ready` at a rising edge.
- `an` output 4: anodes, active low; one-hot-low or all high.
- `digit` output 4: nibble for the decoder; valid while any anode is low.
- `frame_done` output 1: one-cycle pulse on the last cycle of digit 3's SHOW phase.

## Operation
- State machine states: BLANK and SHOW. There is a 2-bit index `idx` and a phase counter `cnt` sized `$clog2(max(DWELL,BLANK))`.
- BLANK: `an`=4'b1111. When `cnt`==BLANK_CYCLES-1, go to SHOW and set `cnt` to 0.
- SHOW: `an[idx]`=0 and all other anodes are 1; `digit`=active[idx]. When `cnt`==DWELL_CYCLES-1, go to BLANK, set `cnt` to 0, and set `idx` to `idx+1` (mod 4, so 3 wraps to 0).
- Frame boundary: the SHOW→BLANK transition with `idx`==3.
- Shadow register:
  - A handshake loads `in_data` into `pending` and sets `pend_full`.
  - At a frame boundary with `pend_full`=1: active ← pending and `pend_full` is cleared.
  - `in_ready` = ~`pend_full`, registered.
- `digit` holds its last value during BLANK.
- Reset values: state=BLANK, `idx`=0, `cnt`=0, active=16'h0000, `pend_full`=0, `an`=4'b1111, `digit`=0, `frame_done`=0, `in_ready`=0. `in_ready` is 0 while `reset_n` is low and becomes 1 on the first edge after release.

## Timing
- Frame length is 4·(BLANK_CYCLES+DWELL_CYCLES) cycles. The first anode goes low BLANK_CYCLES cycles after reset release.
- Accept at edge N: `pend_full`=1 and `in_ready`=0 from N+1.
- Transfer at boundary edge B:
  - the new nibble 0 appears on `digit` at the next SHOW (B+BLANK_CYCLES);
  - `in_ready`=1 from B+1.
- Accept and boundary on the same edge (`pend_full` was 0): the word lands in `pending`. It is not applied in this boundary and waits for the next boundary.
- Boundary with `pend_full`=1 and `in_valid`=1: no accept that edge, because `in_ready` was 0.
- Back-to-back offers while full: `in_valid` is held and `in_data` must remain stable until accepted. There is no drop and no overwrite.
- `reset_n` low mid-frame or mid-handshake: on the next edge all state returns to reset values and any pending word is discarded.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro: `SEG_SCAN_LZB_EN` (leading-zero blanking).
- Defined:
  - During SHOW of digit k>0, `an` stays 4'b1111 if nibbles k..3 of active are all zero.
  - Digit 0 is always lit.
  - Slot timing is unchanged, so frame length is constant.
- Undefined: all four digits are always lit in their SHOW slots.

## Test plan
- Reset/cadence (DWELL=4, BLANK=2):
  - release `reset_n`; `an` sequence is 1111×2, 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, then repeats;
  - `frame_done` pulses every 24 cycles;
  - `digit`=0.
- Load:
  - offer 16'h1A2F mid-frame; `in_ready` drops the next cycle;
  - after the boundary, `digit` is F, 2, A, 1 on anodes 0..3;
  - `in_ready` rises the cycle after the boundary.
- Backpressure:
  - offer 16'h1111 then hold 16'h2222 valid;
  - 16'h2222 is accepted only after the boundary that applies 16'h1111;
  - the next frame shows 2222.
- Boundary collision: an accept on the exact boundary edge is displayed one frame later, not in the immediately following frame.
- Reset mid-frame:
  - assert `reset_n`=0 with `pend_full`=1 during digit 2;
  - the next edge gives `an`=1111, `in_ready`=0, active=0000;
  - the pending word never appears.
- `SEG_SCAN_LZB_EN` defined:
  - with active=16'h0050, anodes 3 and 2 never go low, while anodes 1 and 0 show 5 and 0;
  - with 16'h0000, only digit 0 lights.
